// File: rtl/spi_cmd_if.sv
// Bus bundle between the SPI command engine and its byte receiver,
// latch memory and port bank.
interface spi_cmd_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_PORTS  = 4
);
    logic                   mode_i;
    logic                   cs_active_i;
    logic [7:0]             rx_data_i;
    logic                   rx_stb_i;
    logic [7:0]             tx_data_o;
    logic [ADDR_WIDTH-1:0]  mem_addr_o;
    logic [7:0]             mem_wdata_o;
    logic                   mem_we_o;
    logic [7:0]             mem_rdata_i;
    logic [8*NUM_PORTS-1:0] port_o;
    logic [8*NUM_PORTS-1:0] port_i;
    logic                   cmd_err_o;

    modport slave (
        input  mode_i, cs_active_i, rx_data_i, rx_stb_i,
        input  mem_rdata_i, port_i,
        output tx_data_o, mem_addr_o, mem_wdata_o, mem_we_o,
        output port_o, cmd_err_o
    );

    modport master (
        output mode_i, cs_active_i, rx_data_i, rx_stb_i,
        output mem_rdata_i, port_i,
        input  tx_data_o, mem_addr_o, mem_wdata_o, mem_we_o,
        input  port_o, cmd_err_o
    );
endinterface

// File: rtl/spi_cmd_ctrl.sv
// Byte-level SPI command engine: memory write/read bursts with
// auto-increment and indexed port register access.
module spi_cmd_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_PORTS  = 4
) (
    input logic      clk_i,
    input logic      rst_i,
    spi_cmd_if.slave bus
);
    localparam logic [7:0] ID_BYTE = {4'h2, 4'(ADDR_WIDTH)};

    typedef enum logic [3:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA,
        PW_IDX, PW_DATA, PR_IDX, SINK
    } state_e;

    state_e                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           addr_q, addr_d;
    logic [7:0]                      idx_q, idx_d;
    logic [7:0]                      tx_q, tx_d;
    logic [7:0]                      wdata_q, wdata_d;
    logic                            we_q, we_d;
    logic                            ld_q, ld_d;
    logic                            err_q, err_d;
    logic [NUM_PORTS-1:0][7:0]       port_q, port_d;
    logic [7:0]                      port_rd;
    logic                            stb;

    assign stb = bus.rx_stb_i & bus.cs_active_i & ~bus.mode_i;

    always_comb begin
        port_rd = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (bus.rx_data_i == 8'(k)) port_rd = bus.port_i[8*k +: 8];
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        tx_d    = tx_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        ld_d    = 1'b0;
        err_d   = err_q;
        port_d  = port_q;

        // Post-write increment and delayed read load run one cycle behind the strobe
        if (we_q) addr_d = addr_q + ADDR_WIDTH'(1);
        if (ld_q) tx_d = bus.mem_rdata_i;

        if (bus.mode_i || !bus.cs_active_i) begin
            state_d = IDLE;
            tx_d    = ID_BYTE;
        end else if (stb) begin
            unique case (state_q)
                IDLE: begin
                    case (bus.rx_data_i)
                        8'h00: state_d = IDLE;
                        8'h01: state_d = WR_ADDR;
                        8'h02: state_d = RD_ADDR;
                        8'h03: state_d = PW_IDX;
                        8'h04: state_d = PR_IDX;
                        default: begin
                            err_d   = 1'b1;
                            state_d = SINK;
                        end
                    endcase
                end
                WR_ADDR: begin
                    addr_d  = bus.rx_data_i[ADDR_WIDTH-1:0];
                    state_d = WR_DATA;
                end
                WR_DATA: begin
                    wdata_d = bus.rx_data_i;
                    we_d    = 1'b1;
                end
                RD_ADDR: begin
                    addr_d  = bus.rx_data_i[ADDR_WIDTH-1:0];
                    ld_d    = 1'b1;
                    state_d = RD_DATA;
                end
                RD_DATA: begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    ld_d   = 1'b1;
                end
                PW_IDX: begin
                    idx_d   = bus.rx_data_i;
                    state_d = PW_DATA;
                end
                PW_DATA: begin
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        if (idx_q == 8'(k)) port_d[k] = bus.rx_data_i;
                    end
                    state_d = SINK;
                end
                PR_IDX: begin
                    tx_d    = port_rd;
                    state_d = SINK;
                end
                SINK: state_d = SINK;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            tx_q    <= ID_BYTE;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
            port_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ld_q    <= ld_d;
            err_q   <= err_d;
            port_q  <= port_d;
        end
    end

    assign bus.tx_data_o   = tx_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_we_o    = we_q & ~bus.mode_i;
    assign bus.port_o      = port_q;
    assign bus.cmd_err_o   = err_q;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Directed self-checking bench for spi_cmd_ctrl (ADDR_WIDTH=6, NUM_PORTS=4).
module tb_spi_cmd_ctrl;
    localparam int AW = 6;
    localparam int NP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_cmd_if #(.ADDR_WIDTH(AW), .NUM_PORTS(NP)) bus ();
    spi_cmd_ctrl #(.ADDR_WIDTH(AW), .NUM_PORTS(NP)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    logic [7:0] mem [64];
    assign bus.mem_rdata_i = mem[bus.mem_addr_o];

    int         cyc = 0;
    int         wr_n = 0;
    logic [7:0] wr_a [64];
    logic [7:0] wr_d [64];
    int         wr_c [64];
    int         s_cyc;
    int         n_chk = 0;
    int         n_fail = 0;

    always @(posedge clk) begin
        if (bus.mem_we_o === 1'b1 && wr_n < 64) begin
            wr_a[wr_n] = {2'b00, bus.mem_addr_o};
            wr_d[wr_n] = bus.mem_wdata_o;
            wr_c[wr_n] = cyc;
            wr_n++;
        end
        cyc++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.rx_data_i = b;
        bus.rx_stb_i  = 1'b1;
        s_cyc = cyc;
        @(posedge clk); #1;
        bus.rx_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_frame();
        @(posedge clk); #1;
        bus.cs_active_i = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        bus.cs_active_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.mode_i = 1'b0;
        bus.cs_active_i = 1'b0;
        bus.rx_data_i = 8'h00;
        bus.rx_stb_i = 1'b0;
        bus.port_i = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (bus.tx_data_o !== 8'h26) begin n_fail++;
            $display("FAIL reset_tx: got %h want 26", bus.tx_data_o); end
        n_chk++; if (bus.port_o !== 32'h0) begin n_fail++;
            $display("FAIL reset_port: got %h want 0", bus.port_o); end
        n_chk++; if (bus.mem_we_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_we: got %b want 0", bus.mem_we_o); end
        n_chk++; if (bus.cmd_err_o !== 1'b0) begin n_fail++;
            $display("FAIL reset_err: got %b want 0", bus.cmd_err_o); end
        n_chk++; if (bus.mem_addr_o !== 6'h00) begin n_fail++;
            $display("FAIL reset_addr: got %h want 00", bus.mem_addr_o); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mem_write();
        logic [7:0] d [3];
        int base;
        d[0] = 8'hAA; d[1] = 8'hBB; d[2] = 8'hCC;
        base = wr_n;
        start_frame();
        send_byte(8'h01);
        send_byte(8'h10);
        for (int i = 0; i < 3; i++) begin
            send_byte(d[i]);
            n_chk++; if (wr_n !== base + i + 1) begin n_fail++;
                $display("FAIL wr_count%0d: got %0d want %0d", i, wr_n, base + i + 1); end
            n_chk++; if (wr_c[base+i] !== s_cyc + 1) begin n_fail++;
                $display("FAIL wr_latency%0d: got %0d want %0d", i, wr_c[base+i], s_cyc + 1); end
            n_chk++; if (wr_a[base+i] !== 8'h10 + 8'(i)) begin n_fail++;
                $display("FAIL wr_addr%0d: got %h want %h", i, wr_a[base+i], 8'h10 + 8'(i)); end
            n_chk++; if (wr_d[base+i] !== d[i]) begin n_fail++;
                $display("FAIL wr_data%0d: got %h want %h", i, wr_d[base+i], d[i]); end
        end
        end_frame();
    endtask

    task automatic test_mem_read();
        int base;
        base = wr_n;
        mem[63] = 8'h11;
        mem[0]  = 8'h22;
        mem[1]  = 8'h33;
        start_frame();
        send_byte(8'h02);
        send_byte(8'h3F);
        n_chk++; if (bus.tx_data_o !== 8'h11) begin n_fail++;
            $display("FAIL rd_first: got %h want 11", bus.tx_data_o); end
        send_byte(8'hFF);
        n_chk++; if (bus.tx_data_o !== 8'h22) begin n_fail++;
            $display("FAIL rd_wrap: got %h want 22", bus.tx_data_o); end
        send_byte(8'hFF);
        n_chk++; if (bus.tx_data_o !== 8'h33) begin n_fail++;
            $display("FAIL rd_next: got %h want 33", bus.tx_data_o); end
        n_chk++; if (wr_n !== base) begin n_fail++;
            $display("FAIL rd_nowrite: got %0d want %0d", wr_n, base); end
        end_frame();
        n_chk++; if (bus.tx_data_o !== 8'h26) begin n_fail++;
            $display("FAIL rd_end_id: got %h want 26", bus.tx_data_o); end
    endtask

    task automatic test_port();
        start_frame();
        send_byte(8'h03); send_byte(8'h02); send_byte(8'h5A);
        end_frame();
        n_chk++; if (bus.port_o !== 32'h005A0000) begin n_fail++;
            $display("FAIL pw_idx2: got %h want 005a0000", bus.port_o); end
        start_frame();
        send_byte(8'h03); send_byte(8'h07); send_byte(8'h77);
        end_frame();
        n_chk++; if (bus.port_o !== 32'h005A0000) begin n_fail++;
            $display("FAIL pw_oob: got %h want 005a0000", bus.port_o); end
        bus.port_i = 32'h00A5C300;
        start_frame();
        send_byte(8'h04); send_byte(8'h01);
        n_chk++; if (bus.tx_data_o !== 8'hC3) begin n_fail++;
            $display("FAIL pr_idx1: got %h want c3", bus.tx_data_o); end
        send_byte(8'h44);
        n_chk++; if (bus.tx_data_o !== 8'hC3) begin n_fail++;
            $display("FAIL pr_sink: got %h want c3", bus.tx_data_o); end
        end_frame();
        start_frame();
        send_byte(8'h04); send_byte(8'h07);
        n_chk++; if (bus.tx_data_o !== 8'h00) begin n_fail++;
            $display("FAIL pr_oob: got %h want 00", bus.tx_data_o); end
        end_frame();
        n_chk++; if (bus.cmd_err_o !== 1'b0) begin n_fail++;
            $display("FAIL port_noerr: got %b want 0", bus.cmd_err_o); end
    endtask

    task automatic test_mode();
        int base;
        base = wr_n;
        start_frame();
        send_byte(8'h01); send_byte(8'h05); send_byte(8'hAA);
        n_chk++; if (wr_n !== base + 1 || wr_a[base] !== 8'h05 || wr_d[base] !== 8'hAA) begin
            n_fail++;
            $display("FAIL mode_prewrite: got n=%0d a=%h d=%h want n=%0d a=05 d=aa",
                     wr_n, wr_a[base], wr_d[base], base + 1); end
        @(posedge clk); #1;
        bus.rx_data_i = 8'hBB;
        bus.rx_stb_i  = 1'b1;
        @(posedge clk); #1;
        bus.rx_stb_i = 1'b0;
        bus.mode_i   = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.mem_we_o !== 1'b0) begin n_fail++;
            $display("FAIL mode_we_gate: got %b want 0", bus.mem_we_o); end
        send_byte(8'h09);
        n_chk++; if (bus.cmd_err_o !== 1'b0) begin n_fail++;
            $display("FAIL mode_stb_ignored: got %b want 0", bus.cmd_err_o); end
        n_chk++; if (bus.tx_data_o !== 8'h26) begin n_fail++;
            $display("FAIL mode_idle_id: got %h want 26", bus.tx_data_o); end
        @(posedge clk); #1;
        bus.mode_i = 1'b0;
        send_byte(8'h04); send_byte(8'h02);
        n_chk++; if (bus.tx_data_o !== 8'hA5) begin n_fail++;
            $display("FAIL mode_reopcode: got %h want a5", bus.tx_data_o); end
        n_chk++; if (wr_n !== base + 1) begin n_fail++;
            $display("FAIL mode_nowrite: got %0d want %0d", wr_n, base + 1); end
        end_frame();
    endtask

    task automatic test_frame_end();
        int base;
        base = wr_n;
        start_frame();
        send_byte(8'h01); send_byte(8'h20);
        end_frame();
        n_chk++; if (bus.tx_data_o !== 8'h26) begin n_fail++;
            $display("FAIL fe_id: got %h want 26", bus.tx_data_o); end
        send_byte(8'h77);
        start_frame();
        send_byte(8'h01); send_byte(8'h21);
        @(posedge clk); #1;
        bus.rx_data_i   = 8'h99;
        bus.rx_stb_i    = 1'b1;
        bus.cs_active_i = 1'b0;
        @(posedge clk); #1;
        bus.rx_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (wr_n !== base) begin n_fail++;
            $display("FAIL fe_drop: got %0d want %0d", wr_n, base); end
        start_frame();
        send_byte(8'h04); send_byte(8'h01);
        n_chk++; if (bus.tx_data_o !== 8'hC3) begin n_fail++;
            $display("FAIL fe_reidle: got %h want c3", bus.tx_data_o); end
        end_frame();
    endtask

    task automatic test_bad_opcode();
        int base;
        base = wr_n;
        start_frame();
        send_byte(8'h09); send_byte(8'h01); send_byte(8'h02);
        end_frame();
        n_chk++; if (bus.cmd_err_o !== 1'b1) begin n_fail++;
            $display("FAIL bad_err: got %b want 1", bus.cmd_err_o); end
        n_chk++; if (wr_n !== base || bus.port_o !== 32'h005A0000) begin n_fail++;
            $display("FAIL bad_noeffect: got n=%0d port=%h want n=%0d port=005a0000",
                     wr_n, bus.port_o, base); end
        start_frame();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h55);
        end_frame();
        n_chk++; if (wr_n !== base + 1 || wr_a[base] !== 8'h00 || wr_d[base] !== 8'h55) begin
            n_fail++;
            $display("FAIL bad_then_write: got n=%0d a=%h d=%h want n=%0d a=00 d=55",
                     wr_n, wr_a[base], wr_d[base], base + 1); end
        n_chk++; if (bus.cmd_err_o !== 1'b1) begin n_fail++;
            $display("FAIL bad_sticky: got %b want 1", bus.cmd_err_o); end
    endtask

    initial begin
        test_reset();
        test_mem_write();
        test_mem_read();
        test_port();
        test_mode();
        test_frame_end();
        test_bad_opcode();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
